// File: rtl/t08_bus_ctrl.sv
// Single-beat Wishbone master behind the t08 load/store handler; reads of I2C_ADDR are served from the I2C receiver.
// Optional ack timeout is compiled in with `define BUS_TIMEOUT_EN.
module t08_bus_ctrl #(
    parameter logic [31:0] I2C_ADDR = 32'd923923,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic [31:0] i2c_rdata,
    input  logic        i2c_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_I2C_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] w_rdata_next;
    logic [31:0] w_adr_next;
    logic [31:0] w_dat_next;
    logic        w_we_next;
    logic        w_cyc_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic        w_err_next;

`ifdef BUS_TIMEOUT_EN
    logic [7:0]  r_tmo_cnt;
    logic [7:0]  w_tmo_next;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
`endif

    assign wb_sel_o = 4'hF;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_rdata_next = rdata;
        w_adr_next   = wb_adr_o;
        w_dat_next   = wb_dat_o;
        w_we_next    = wb_we_o;
        w_cyc_next   = wb_cyc_o;
        w_busy_next  = busy;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_tmo_next   = r_tmo_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
`ifdef BUS_TIMEOUT_EN
                w_tmo_next  = 8'd0;
`endif
                // Writes always go to the bus, even at the I2C address.
                if (req_write) begin
                    w_adr_next   = {req_addr[31:2], 2'b00};
                    w_dat_next   = req_wdata;
                    w_we_next    = 1'b1;
                    w_cyc_next   = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = S_BUS;
                end else if (req_read && req_addr == I2C_ADDR) begin
                    w_busy_next  = 1'b1;
                    w_state_next = S_I2C_WAIT;
                end else if (req_read) begin
                    w_adr_next   = {req_addr[31:2], 2'b00};
                    w_we_next    = 1'b0;
                    w_cyc_next   = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    if (!wb_we_o) w_rdata_next = wb_dat_i;
                    w_cyc_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = S_RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    if (!wb_we_o) w_rdata_next = 32'h0;
                    w_cyc_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_tmo_next = r_tmo_cnt + 8'd1;
                end
`endif
            end
            S_I2C_WAIT: begin
                if (i2c_valid) begin
                    w_rdata_next = i2c_rdata;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            rdata    <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            rdata    <= w_rdata_next;
            busy     <= w_busy_next;
            done     <= w_done_next;
            wb_adr_o <= w_adr_next;
            wb_dat_o <= w_dat_next;
            wb_we_o  <= w_we_next;
            wb_cyc_o <= w_cyc_next;
            wb_stb_o <= w_cyc_next;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
            err       <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_next;
            err       <= w_err_next;
        end
    end
`else
    assign err = 1'b0;
    logic w_unused;
    assign w_unused = w_err_next;
`endif

endmodule

// File: doc/t08_bus_ctrl.md
Name: t08_bus_ctrl

Overview:
- Memory-side stage directly downstream of the t08 load/store handler.
- Accepts the handler's read/write strobes, address and store data, and runs one single-beat Wishbone master transaction per request.
- Serves reads of the I2C data address from the I2C receiver interface instead of the bus.
- Returns read data, busy and done to the handler, so the handler freezes the core while a transaction is outstanding.

Parameters:
- I2C_ADDR, 32'd923923, word address whose reads are serviced from the I2C interface.
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i before aborting (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_addr  in  32  byte address from handler.
- req_wdata  in  32  store data from handler.
- req_read  in  1  read request, level, sampled in IDLE.
- req_write  in  1  write request, level, sampled in IDLE.
- rdata  out  32  read data to handler.
- busy  out  1  transaction outstanding.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse, coincident with done.
- wb_adr_o  out  32  word-aligned bus address.
- wb_dat_o  out  32  bus write data.
- wb_sel_o  out  4  byte selects, always 4'hF.
- wb_we_o  out  1  bus write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge.
- i2c_rdata  in  32  I2C receive word.
- i2c_valid  in  1  I2C word available, single-cycle pulse.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - rdata, busy, done, err, wb_* outputs all 0; the timeout counter clears.
  - A transaction in flight is abandoned: cyc/stb drop at that edge and no done is issued.
- All outputs are registered. wb_sel_o is the constant 4'hF.
- IDLE:
  - busy=0. Requests are sampled only in this state.
  - If req_write=1 (write wins over a simultaneous read): latch address and data. Drive wb_adr_o={req_addr[31:2],2'b00}, wb_dat_o=req_wdata, wb_we_o=1, cyc=stb=1, busy=1, then go to BUS. This applies even when req_addr==I2C_ADDR, since writes always go to the bus.
  - Else if req_read=1 and req_addr==I2C_ADDR: busy=1, go to I2C_WAIT.
  - Else if req_read=1: set up a bus read as for a write but with wb_we_o=0, busy=1, go to BUS.
- BUS:
  - Hold cyc/stb/we/adr/dat stable.
  - On wb_ack_i=1: if the transaction is a read, rdata<=wb_dat_i. Drop cyc/stb/we and go to RESP.
  - The minimum request-to-done latency is 2 cycles when ack arrives in the first BUS cycle.
- I2C_WAIT:
  - On i2c_valid=1: rdata<=i2c_rdata, go to RESP.
  - An i2c_valid pulse seen in any other state is ignored and not buffered.
- RESP:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - Requests still asserted during RESP are not accepted. The earliest next acceptance is the first IDLE cycle, so back-to-back requests complete every 3+ cycles.
- rdata holds its value until the next successful read completes; writes do not change it.
- wb_ack_i arriving outside BUS is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: drop cyc/stb, rdata<=32'h0 for a read, err=1 together with done in RESP.
  - An ack arriving on the same cycle as the expiry wins: normal completion, err=0.
  - I2C_WAIT is not timed.
- Undefined: BUS waits indefinitely, err is tied to 0, and no counter logic exists.

Test Plan:
- Reset check: rst=1 for 2 cycles with req_read=1 -> all outputs 0 and no cyc; after rst=0 the request is accepted on the first IDLE edge.
- Bus read: req_read=1, addr=32'h0000_0106, ack after 3 wait cycles with wb_dat_i=32'hCAFE_F00D.
  - wb_adr_o=32'h0000_0104, we=0.
  - busy high through BUS.
  - done pulses one cycle after ack with rdata=32'hCAFE_F00D.
- Simultaneous read and write: req_write=1 and req_read=1, addr=32'h40, wdata=32'h1234_5678 -> write wins, we=1, wb_dat_o=32'h1234_5678, rdata unchanged after done.
- I2C read: read at addr 923923, i2c_valid pulses 5 cycles later with i2c_rdata=32'h0000_00A5.
  - No cyc asserted.
  - rdata=32'hA5, done one cycle after valid.
  - A valid pulse sent earlier in IDLE is ignored.
- Timeout with BUS_TIMEOUT_EN, TIMEOUT=4: bus read with no ack -> cyc drops after 4 BUS cycles; done and err pulse together; rdata=0. With the macro undefined, busy stays high indefinitely.
- Reset mid-transaction: rst=1 during BUS -> cyc/stb are 0 at the next edge; done is never asserted for the abandoned request.
